// File: rtl/md_seq_pkg.sv
// Shared types and constants for the multiply/divide operand sequencer.
// Holds the FSM state encoding, word/window widths and the quotient bit-pair encoding.
package md_seq_pkg;

  localparam int MD_WORD_W = 26;
  localparam int MD_WIN_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FIN  = 2'd3
  } md_state_e;

  // A non-negative partial remainder yields a 1 quotient bit.
  function automatic logic [1:0] md_qbits(input logic sg1, input logic sg2);
    return {~sg1, ~sg2};
  endfunction

endpackage

// File: rtl/md_shift_window.sv
// Loadable two-bit-per-step shift register with a 3-bit tap on its low end.
// SHIFT_LEFT=0 walks a multiplier window; SHIFT_LEFT=1 assembles quotient bit pairs.
module md_shift_window
  import md_seq_pkg::*;
#(
  parameter int W          = MD_WORD_W + 1,
  parameter bit SHIFT_LEFT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [W-1:0]        load_val,
  input  logic                shift,
  input  logic [1:0]          shift_in,
  output logic [W-1:0]        data,
  output logic [MD_WIN_W-1:0] win
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift) begin
      if (SHIFT_LEFT) data_d = {data_q[W-3:0], shift_in};
      else            data_d = {shift_in, data_q[W-1:2]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data = data_q;
  assign win  = data_q[MD_WIN_W-1:0];

endmodule

// File: rtl/md_operand_sequencer.sv
// Initiator for the MD step unit: feeds radix-4 multiplier windows and
// collects SG1/SG2 decisions into a quotient, one two-bit step at a time.
//
// state | meaning
// IDLE  | waiting for start; operands and quotient loaded on accept
// REQ   | latch window, raise step_req for the next cycle
// WAIT  | step_req held until step_ack; shift and count on ack
// FIN   | one-cycle done, quotient marked valid after a divide
module md_operand_sequencer
  import md_seq_pkg::*;
#(
  parameter int WORD_W = MD_WORD_W,
  parameter int STEPS  = WORD_W / 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op_div,
  input  logic [WORD_W-1:0]   operand,
  output logic                busy,
  output logic                step_req,
  output logic [MD_WIN_W-1:0] md_win,
  input  logic                step_ack,
  input  logic                sg1,
  input  logic                sg2,
  output logic                done,
  output logic [WORD_W-1:0]   quotient,
  output logic                q_valid
);

  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_div_q, op_div_d;
  logic                step_req_q, step_req_d;
  logic [MD_WIN_W-1:0] md_win_q, md_win_d;
  logic                q_valid_q, q_valid_d;

  logic                accept, ack_hit;
  logic [MD_WIN_W-1:0] sr_win;
  logic [WORD_W:0]     sr_data_unused;
  logic [MD_WIN_W-1:0] q_win_unused;
  logic [WORD_W-1:0]   q_data;

  assign accept  = (state_q == IDLE) && start;
  assign ack_hit = (state_q == WAIT) && step_ack;

  md_shift_window #(.W(WORD_W + 1), .SHIFT_LEFT(1'b0)) u_mult_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val ({operand, 1'b0}),
    .shift    (ack_hit),
    .shift_in (2'b00),
    .data     (sr_data_unused),
    .win      (sr_win)
  );

  md_shift_window #(.W(WORD_W), .SHIFT_LEFT(1'b1)) u_quot_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && op_div),
    .load_val ('0),
    .shift    (ack_hit && op_div_q),
    .shift_in (md_qbits(sg1, sg2)),
    .data     (q_data),
    .win      (q_win_unused)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_div_d   = op_div_q;
    step_req_d = step_req_q;
    md_win_d   = md_win_q;
    q_valid_d  = q_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = REQ;
          cnt_d    = '0;
          op_div_d = op_div;
          if (op_div) q_valid_d = 1'b0;
        end
      end
      REQ: begin
        step_req_d = 1'b1;
        md_win_d   = op_div_q ? '0 : sr_win;
        state_d    = WAIT;
      end
      WAIT: begin
        if (step_ack) begin
          step_req_d = 1'b0;
          md_win_d   = '0;
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = (cnt_q == LAST_STEP) ? FIN : REQ;
        end
      end
      FIN: begin
        q_valid_d = q_valid_q | op_div_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_div_q   <= 1'b0;
      step_req_q <= 1'b0;
      md_win_q   <= '0;
      q_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_div_q   <= op_div_d;
      step_req_q <= step_req_d;
      md_win_q   <= md_win_d;
      q_valid_q  <= q_valid_d;
    end
  end

  // q_valid must already read high during the done cycle of a divide.
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign step_req = step_req_q;
  assign md_win   = md_win_q;
  assign quotient = q_data;
  assign q_valid  = q_valid_q | (done & op_div_q);

endmodule

// File: tb/tb_md_operand_sequencer.sv
// Scoreboard bench for md_operand_sequencer: stimulus pushes expected windows
// and results; a negedge monitor pops and compares as the DUT presents them.
module tb_md_operand_sequencer;

  localparam int W     = 26;
  localparam int STEPS = 13;

  logic          clk, rst_n, start, op_div, step_ack, sg1, sg2;
  logic [W-1:0]  operand;
  logic          busy, step_req, done, q_valid;
  logic [2:0]    md_win;
  logic [W-1:0]  quotient;

  md_operand_sequencer #(.WORD_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_div   (op_div),
    .operand  (operand),
    .busy     (busy),
    .step_req (step_req),
    .md_win   (md_win),
    .step_ack (step_ack),
    .sg1      (sg1),
    .sg2      (sg2),
    .done     (done),
    .quotient (quotient),
    .q_valid  (q_valid)
  );

  typedef struct {
    logic [W-1:0] q;
    logic         qv;
    int           lat;
  } res_t;

  logic [2:0] exp_win_q[$];
  res_t       exp_res_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         t_start = 0;
  int         nreq = 0;
  logic       req_prev = 1'b0;
  logic [2:0] cur_win = 3'b000;
  logic [W-1:0] model_q = '0;
  logic       model_qv = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: windows on every cycle a request is up, results on done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (step_req && !req_prev) begin
        nreq++;
        if (exp_win_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL win_unexpected actual=step_req required=no_request");
        end else begin
          cur_win = exp_win_q.pop_front();
        end
      end
      if (step_req) chk("md_win", {29'd0, md_win}, {29'd0, cur_win});
      req_prev = step_req;
      if (done) begin
        if (exp_res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected actual=done required=no_done");
        end else begin
          res_t r;
          r = exp_res_q.pop_front();
          chk("latency", cyc - t_start, r.lat);
          chk("quotient", {6'd0, quotient}, {6'd0, r.q});
          chk("q_valid", {31'd0, q_valid}, {31'd0, r.qv});
          chk("step_count", nreq, STEPS);
        end
        nreq = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_step_req"}, {31'd0, step_req}, 0);
    chk({tag, "_md_win"}, {29'd0, md_win}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_quotient"}, {6'd0, quotient}, 0);
    chk({tag, "_q_valid"}, {31'd0, q_valid}, 0);
  endtask

  // Runs one operation; d = WAIT cycles per step (ack in the d-th one).
  task automatic run_op(input logic div, input logic [W-1:0] opnd, input int d,
                        input logic s1, input logic s2, input logic [W-1:0] exp_q,
                        input logic [2:0] w0, input logic [2:0] w1, input logic [2:0] wrest,
                        input logic disturb, input int rst_after);
    res_t r;
    int   budget;
    int   nack;
    exp_win_q.push_back(w0);
    exp_win_q.push_back(w1);
    for (int i = 2; i < STEPS; i++) exp_win_q.push_back(wrest);
    r.q   = div ? exp_q : model_q;
    r.qv  = div ? 1'b1 : model_qv;
    r.lat = STEPS * (d + 1) + 1;
    exp_res_q.push_back(r);

    start = 1'b1; op_div = div; operand = opnd;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0; operand = '0; op_div = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 1);
    chk("q_at_start", {6'd0, quotient}, div ? 32'd0 : {6'd0, model_q});
    chk("qv_at_start", {31'd0, q_valid}, div ? 32'd0 : {31'd0, model_qv});
    if (div) begin model_q = exp_q; model_qv = 1'b1; end

    budget = 2000;
    nack = 0;
    while (budget > 0) begin
      if (done) break;
      if (step_req) begin
        repeat (d - 1) @(negedge clk);
        step_ack = 1'b1; sg1 = s1; sg2 = s2;
        @(negedge clk);
        step_ack = 1'b0; sg1 = 1'b0; sg2 = 1'b0;
        nack++;
        if (rst_after != 0 && nack == rst_after) begin
          chk("q_partial", {6'd0, quotient}, 32'h0000AAA);
          #2 rst_n = 1'b0;
          #1 check_all_zero("async_rst");
          exp_win_q.delete();
          exp_res_q.delete();
          nreq = 0;
          model_q = '0; model_qv = 1'b0;
          repeat (2) @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (disturb && nack == 3) begin
          start = 1'b1; op_div = ~div; operand = 26'h1234567;
          step_ack = 1'b1; sg1 = ~s1; sg2 = ~s2;
          @(negedge clk);
          start = 1'b0; op_div = 1'b0; operand = '0;
          step_ack = 1'b0; sg1 = 1'b0; sg2 = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL op_timeout actual=no_done required=done");
    end
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 0);
    chk("busy_idle", {31'd0, busy}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op_div = 1'b0; operand = '0;
    step_ack = 1'b0; sg1 = 1'b0; sg2 = 1'b0;
    #12 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Stray ack while idle must not start anything.
    step_ack = 1'b1; sg1 = 1'b1; sg2 = 1'b1;
    @(negedge clk);
    step_ack = 1'b0; sg1 = 1'b0; sg2 = 1'b0;
    @(negedge clk);
    chk("stray_idle_busy", {31'd0, busy}, 0);
    chk("stray_idle_req", {31'd0, step_req}, 0);

    run_op(1'b0, 26'h0000005, 1, 1'b0, 1'b0, '0, 3'b010, 3'b010, 3'b000, 1'b0, 0);
    run_op(1'b0, 26'h3FFFFFF, 1, 1'b0, 1'b0, '0, 3'b110, 3'b111, 3'b111, 1'b0, 0);
    run_op(1'b1, 26'h0000000, 1, 1'b0, 1'b1, 26'h2AAAAAA, 3'b000, 3'b000, 3'b000, 1'b0, 0);
    run_op(1'b1, 26'h0000000, 5, 1'b1, 1'b0, 26'h1555555, 3'b000, 3'b000, 3'b000, 1'b0, 0);
    run_op(1'b0, 26'h0000005, 2, 1'b0, 1'b0, '0, 3'b010, 3'b010, 3'b000, 1'b0, 0);
    run_op(1'b1, 26'h0000000, 1, 1'b0, 1'b1, 26'h2AAAAAA, 3'b000, 3'b000, 3'b000, 1'b1, 0);
    run_op(1'b1, 26'h0000000, 1, 1'b0, 1'b1, 26'h2AAAAAA, 3'b000, 3'b000, 3'b000, 1'b0, 6);
    @(negedge clk);
    check_all_zero("post_rst");
    run_op(1'b1, 26'h0000000, 1, 1'b0, 1'b1, 26'h2AAAAAA, 3'b000, 3'b000, 3'b000, 1'b0, 0);

    repeat (3) @(negedge clk);
    if (exp_win_q.size() != 0 || exp_res_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover_expect actual=%0d/%0d required=0/0", exp_win_q.size(), exp_res_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
